// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint: 7-bit address match, register pointer, local register bus.
// SCL/SDA are synchronized and glitch-filtered; all bus events are decoded from the filtered lines.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         PTR_W    = 8,
  parameter int         FILT     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_scl_i,
  input  logic             io_sda_i,
  output logic             io_sda_o,
  output logic             io_sda_t,
  output logic             io_wr_en,
  output logic [PTR_W-1:0] io_wr_addr,
  output logic [7:0]       io_wr_data,
  output logic [PTR_W-1:0] io_rd_addr,
  input  logic [7:0]       io_rd_data,
  output logic             io_busy,
  output logic             io_addressed,
  output logic             io_nack
);

  localparam int CW = (FILT < 2) ? 1 : $clog2(FILT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_PTR, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  logic          scl_meta_q, scl_sync_q, scl_f_q, scl_p_q;
  logic          sda_meta_q, sda_sync_q, sda_f_q, sda_p_q;
  logic [CW-1:0] scl_cnt_q, sda_cnt_q;

  // A filtered line only flips after FILT consecutive samples disagree with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_f_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      sda_cnt_q  <= '0;
    end else begin
      scl_meta_q <= io_scl_i;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= io_sda_i;
      sda_sync_q <= sda_meta_q;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      if (scl_sync_q == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CW'(FILT - 1)) begin
        scl_f_q   <= scl_sync_q;
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_sync_q == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CW'(FILT - 1)) begin
        sda_f_q   <= sda_sync_q;
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_ev = scl_f_q & scl_p_q & ~sda_f_q & sda_p_q;
  assign stop_ev  = scl_f_q & scl_p_q & sda_f_q & ~sda_p_q;

  state_t           state_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       sh_q;
  logic [PTR_W-1:0] ptr_q, wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             rw_q, sda_t_q, busy_q, addressed_q, wr_en_q, nack_q;

  // bit_cnt_q: 0..8 data bits, 9 = acknowledge bit in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      nack_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      nack_q  <= 1'b0;
      if (start_ev) begin
        state_q     <= S_ADDR;
        bit_cnt_q   <= '0;
        sda_t_q     <= 1'b1;
        busy_q      <= 1'b1;
        addressed_q <= 1'b0;
      end else if (stop_ev) begin
        state_q     <= S_IDLE;
        bit_cnt_q   <= '0;
        sda_t_q     <= 1'b1;
        busy_q      <= 1'b0;
        addressed_q <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              sh_q      <= {sh_q[6:0], sda_f_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd9;
              sda_t_q   <= 1'b0;
              if (state_q == S_ADDR) begin
                if (sh_q[7:1] == DEV_ADDR) begin
                  addressed_q <= 1'b1;
                  rw_q        <= sh_q[0];
                end else begin
                  state_q   <= S_IGNORE;
                  sda_t_q   <= 1'b1;
                  bit_cnt_q <= '0;
                end
              end else if (state_q == S_PTR) begin
                ptr_q <= PTR_W'(sh_q);
              end else begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= sh_q;
                ptr_q     <= ptr_q + 1'b1;
              end
            end else if (scl_fall && bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              sda_t_q   <= 1'b1;
              if (state_q == S_ADDR && rw_q) begin
                state_q <= S_RDATA;
                sh_q    <= io_rd_data;
                sda_t_q <= io_rd_data[7];
              end else if (state_q == S_ADDR) begin
                state_q <= S_PTR;
              end else begin
                state_q <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              if (bit_cnt_q < 4'd8) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end else if (bit_cnt_q == 4'd8) begin
                if (!sda_f_q) begin
                  ptr_q     <= ptr_q + 1'b1;
                  bit_cnt_q <= 4'd9;
                end else begin
                  nack_q    <= 1'b1;
                  state_q   <= S_IGNORE;
                  bit_cnt_q <= '0;
                end
              end
            end else if (scl_fall) begin
              if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
                sh_q    <= {sh_q[6:0], 1'b0};
                sda_t_q <= sh_q[6];
              end else if (bit_cnt_q == 4'd8) begin
                sda_t_q <= 1'b1;
              end else if (bit_cnt_q == 4'd9) begin
                sh_q      <= io_rd_data;
                sda_t_q   <= io_rd_data[7];
                bit_cnt_q <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_sda_o     = 1'b0;
  assign io_sda_t     = sda_t_q;
  assign io_wr_en     = wr_en_q;
  assign io_wr_addr   = wr_addr_q;
  assign io_wr_data   = wr_data_q;
  assign io_rd_addr   = ptr_q;
  assign io_busy      = busy_q;
  assign io_addressed = addressed_q;
  assign io_nack      = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bench for i2c_target: bit-banged I2C master with write/read scoreboards.
module tb_i2c_target;
  localparam int Q = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       io_sda_o, io_sda_t, io_wr_en, io_busy, io_addressed, io_nack;
  logic [7:0] io_wr_addr, io_wr_data, io_rd_addr, io_rd_data;
  int         checks = 0;
  int         errors = 0;
  int         nack_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  exp_rd_q[$];

  always #5 clock = ~clock;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus    = sda_m & (io_sda_t | io_sda_o);
  assign io_rd_data = io_rd_addr ^ 8'hFF;

  i2c_target #(.DEV_ADDR(7'h50), .PTR_W(8), .FILT(3)) dut (
    .clock(clock), .reset(reset), .io_scl_i(scl_m), .io_sda_i(sda_bus),
    .io_sda_o(io_sda_o), .io_sda_t(io_sda_t), .io_wr_en(io_wr_en),
    .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data), .io_rd_addr(io_rd_addr),
    .io_rd_data(io_rd_data), .io_busy(io_busy), .io_addressed(io_addressed),
    .io_nack(io_nack)
  );

  always @(negedge clock) begin
    if (io_wr_en) obs_q.push_back({io_wr_addr, io_wr_data});
    if (io_nack) nack_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq(Q); scl_m = 1'b1; wq(Q);
      if (i == glitch_bit) begin
        scl_m = 1'b0; wq(1); scl_m = 1'b1; wq(Q-1);
      end else begin
        wq(Q);
      end
      scl_m = 1'b0; wq(Q);
    end
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); ack = sda_bus; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic rd_byte(input logic master_ack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(Q); scl_m = 1'b1; wq(Q); d[i] = sda_bus; wq(Q); scl_m = 1'b0;
    end
    sda_m = ~master_ack; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0; wq(Q); sda_m = 1'b1;
  endtask

  task automatic test_reset;
    wq(3);
    checks++; if (io_sda_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t: got %b want 1", io_sda_t); end
    checks++; if (io_sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda_o: got %b want 0", io_sda_o); end
    checks++; if ({io_wr_en, io_busy, io_addressed, io_nack} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {io_wr_en, io_busy, io_addressed, io_nack});
    end
    checks++; if ({io_wr_addr, io_wr_data, io_rd_addr} !== 24'h0) begin
      errors++; $display("FAIL reset_buses: got %h want 000000", {io_wr_addr, io_wr_data, io_rd_addr});
    end
    reset = 1'b1;
    wq(5);
  endtask

  task automatic test_write;
    logic [7:0] bytes [4];
    logic ack;
    logic [15:0] e, o;
    bytes = '{8'hA0, 8'h10, 8'h3C, 8'h5A};
    exp_q.push_back({8'h10, 8'h3C});
    exp_q.push_back({8'h11, 8'h5A});
    i2c_start;
    for (int i = 0; i < 4; i++) begin
      wr_byte(bytes[i], -1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_ack%0d: got %b want 0", i, ack); end
    end
    checks++; if ({io_busy, io_addressed} !== 2'b11) begin
      errors++; $display("FAIL write_busy_addressed: got %b want 11", {io_busy, io_addressed});
    end
    i2c_stop;
    checks++; if ({io_busy, io_addressed} !== 2'b00) begin
      errors++; $display("FAIL write_after_stop: got %b want 00", {io_busy, io_addressed});
    end
    checks++; if (io_rd_addr !== 8'h12) begin errors++; $display("FAIL write_ptr: got %h want 12", io_rd_addr); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL write_sb: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL write_sb: got %h want %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL write_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_mismatch;
    logic ack;
    i2c_start;
    wr_byte(8'hA2, -1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mismatch_addr_ack: got %b want 1", ack); end
    checks++; if ({io_busy, io_addressed} !== 2'b10) begin
      errors++; $display("FAIL mismatch_flags: got %b want 10", {io_busy, io_addressed});
    end
    wr_byte(8'h11, -1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mismatch_data_ack: got %b want 1", ack); end
    i2c_stop;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mismatch_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_read;
    logic ack;
    logic [7:0] d, e;
    int n0;
    n0 = nack_cnt;
    i2c_start;
    wr_byte(8'hA0, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_waddr_ack: got %b want 0", ack); end
    wr_byte(8'h7F, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_ptr_ack: got %b want 0", ack); end
    i2c_start;
    exp_rd_q.push_back(8'h80);
    exp_rd_q.push_back(8'h7F);
    wr_byte(8'hA1, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_raddr_ack: got %b want 0", ack); end
    checks++; if (io_rd_addr !== 8'h7F) begin errors++; $display("FAIL read_addr0: got %h want 7f", io_rd_addr); end
    rd_byte(1'b1, d);
    e = exp_rd_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL read_byte0: got %h want %h", d, e); end
    checks++; if (io_rd_addr !== 8'h80) begin errors++; $display("FAIL read_addr1: got %h want 80", io_rd_addr); end
    rd_byte(1'b0, d);
    e = exp_rd_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL read_byte1: got %h want %h", d, e); end
    i2c_stop;
    checks++; if (nack_cnt - n0 != 1) begin errors++; $display("FAIL read_nack_pulses: got %0d want 1", nack_cnt - n0); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL read_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_wrap;
    logic [7:0] bytes [4];
    logic ack;
    logic [15:0] e, o;
    bytes = '{8'hA0, 8'hFF, 8'h01, 8'h02};
    exp_q.push_back({8'hFF, 8'h01});
    exp_q.push_back({8'h00, 8'h02});
    i2c_start;
    for (int i = 0; i < 4; i++) begin
      wr_byte(bytes[i], -1, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wrap_ack%0d: got %b want 0", i, ack); end
    end
    i2c_stop;
    checks++; if (io_rd_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr: got %h want 01", io_rd_addr); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_sb: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wrap_sb: got %h want %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_glitch;
    logic ack;
    logic [15:0] e, o;
    exp_q.push_back({8'h20, 8'hC3});
    i2c_start;
    wr_byte(8'hA0, -1, ack);
    wr_byte(8'h20, -1, ack);
    wr_byte(8'hC3, 3, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL glitch_ack: got %b want 0", ack); end
    i2c_stop;
    checks++; if (io_rd_addr !== 8'h21) begin errors++; $display("FAIL glitch_ptr: got %h want 21", io_rd_addr); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL glitch_sb: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL glitch_sb: got %h want %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_read;
    logic ack;
    logic [15:0] e, o;
    i2c_start;
    wr_byte(8'hA0, -1, ack);
    wr_byte(8'h80, -1, ack);
    i2c_start;
    wr_byte(8'hA1, -1, ack);
    checks++; if (io_sda_t !== 1'b0) begin errors++; $display("FAIL midread_driving: got %b want 0", io_sda_t); end
    #2 reset = 1'b0;
    #1;
    checks++; if (io_sda_t !== 1'b1) begin errors++; $display("FAIL midread_async_release: got %b want 1", io_sda_t); end
    checks++; if ({io_busy, io_addressed, io_rd_addr} !== 10'h0) begin
      errors++; $display("FAIL midread_async_state: got %h want 000", {io_busy, io_addressed, io_rd_addr});
    end
    scl_m = 1'b1; sda_m = 1'b1;
    wq(5);
    reset = 1'b1;
    wq(10);
    exp_q.push_back({8'h05, 8'h99});
    i2c_start;
    wr_byte(8'hA0, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL postreset_ack: got %b want 0", ack); end
    wr_byte(8'h05, -1, ack);
    wr_byte(8'h99, -1, ack);
    i2c_stop;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL postreset_sb: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL postreset_sb: got %h want %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL postreset_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read;
    test_wrap;
    test_glitch;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
